// File: rtl/seg_pkg.sv
// Shared widths, default video timing and types for the segment sequencer.
package seg_pkg;

    localparam int X_W = 11;
    localparam int Y_W = 10;

    localparam int DEF_MAX_SEGS = 8;
    localparam int DEF_H_ACTIVE = 1024;
    localparam int DEF_H_TOTAL  = 1344;
    localparam int DEF_V_ACTIVE = 768;
    localparam int DEF_V_TOTAL  = 806;

    typedef struct packed {
        logic [X_W-1:0] start_x;
        logic [X_W-1:0] end_x;
        logic [Y_W-1:0] start_y;
        logic [Y_W-1:0] end_y;
    } seg_t;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        LOAD
    } state_t;

endpackage

// File: rtl/seg_bank.sv
// Two-bank segment register file: one write port, one combinational read port.
// The MSB of each address selects the bank.
module seg_bank
    import seg_pkg::*;
#(
    parameter int IDX_W = 3
) (
    input  logic           clk,
    input  logic           wr_en,
    input  logic [IDX_W:0] wr_addr,
    input  seg_t           wr_data,
    input  logic [IDX_W:0] rd_addr,
    output seg_t           rd_data
);

    seg_t mem [2**(IDX_W+1)];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/segment_sequencer.sv
// Double-buffered segment table with a per-line search that hands the line
// renderer stable endpoints, updated only during horizontal blanking.
module segment_sequencer
    import seg_pkg::*;
#(
    parameter int MAX_SEGS = DEF_MAX_SEGS,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_TOTAL  = DEF_H_TOTAL,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_TOTAL  = DEF_V_TOTAL
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [X_W-1:0]              hcount,
    input  logic [Y_W-1:0]              vcount,
    input  logic                        wr_en,
    input  logic [$clog2(MAX_SEGS)-1:0] wr_idx,
    input  logic [X_W-1:0]              wr_start_x,
    input  logic [X_W-1:0]              wr_end_x,
    input  logic [Y_W-1:0]              wr_start_y,
    input  logic [Y_W-1:0]              wr_end_y,
    input  logic                        wr_commit,
    input  logic [$clog2(MAX_SEGS):0]   wr_count,
    output logic                        wr_ready,
    output logic [X_W-1:0]              start_x,
    output logic [X_W-1:0]              end_x,
    output logic [Y_W-1:0]              start_y,
    output logic [Y_W-1:0]              end_y,
    output logic                        seg_valid,
    output logic                        frame_swapped
);

    localparam int IDX_W = $clog2(MAX_SEGS);
    localparam int CNT_W = IDX_W + 1;

    if (H_TOTAL - H_ACTIVE <= MAX_SEGS + 2) begin : g_blanking_check
        $error("horizontal blanking too short to scan MAX_SEGS entries");
    end

    logic             bank_sel;
    logic             pending;
    logic [CNT_W-1:0] front_count;
    logic [CNT_W-1:0] pend_count;
    logic [CNT_W-1:0] commit_count;

    state_t           state_q;
    state_t           state_d;
    logic [IDX_W-1:0] scan_idx;
    logic             scan_bank;
    logic [Y_W-1:0]   tgt_q;
    logic             found_q;
    seg_t             match_q;

    seg_t             wr_seg;
    seg_t             rd_seg;
    logic             swap_pos;
    logic             swap_now;
    logic             wr_accept;
    logic             search_start;
    logic             last_entry;
    logic             entry_hit;
    logic [Y_W-1:0]   line_tgt;
    logic [Y_W-1:0]   y_lo;
    logic [Y_W-1:0]   y_hi;

    // The frame-boundary cycle always blocks writes, even when no swap is pending.
    assign swap_pos      = (hcount == '0) && (vcount == Y_W'(V_ACTIVE));
    assign swap_now      = swap_pos && pending;
    assign wr_ready      = !swap_pos;
    assign frame_swapped = swap_now;

    assign wr_accept    = wr_en && wr_ready && (32'(wr_idx) < MAX_SEGS);
    assign wr_seg       = '{start_x: wr_start_x, end_x: wr_end_x,
                            start_y: wr_start_y, end_y: wr_end_y};
    assign commit_count = (wr_count > CNT_W'(MAX_SEGS)) ? CNT_W'(MAX_SEGS) : wr_count;

    seg_bank #(
        .IDX_W   (IDX_W)
    ) u_bank (
        .clk     (clk),
        .wr_en   (wr_accept),
        .wr_addr ({~bank_sel, wr_idx}),
        .wr_data (wr_seg),
        .rd_addr ({scan_bank, scan_idx}),
        .rd_data (rd_seg)
    );

    // A commit landing on the swap cycle re-arms pending for the following frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bank_sel    <= 1'b0;
            front_count <= '0;
            pending     <= 1'b0;
            pend_count  <= '0;
        end else begin
            if (swap_now) begin
                bank_sel    <= ~bank_sel;
                front_count <= pend_count;
            end
            if (wr_commit) begin
                pending    <= 1'b1;
                pend_count <= commit_count;
            end else if (swap_now) begin
                pending <= 1'b0;
            end
        end
    end

    assign line_tgt     = (vcount == Y_W'(V_TOTAL - 1)) ? '0 : vcount + 1'b1;
    assign search_start = (hcount == X_W'(H_ACTIVE));
    assign last_entry   = (scan_idx == IDX_W'(MAX_SEGS - 1));
    assign y_lo         = (rd_seg.start_y < rd_seg.end_y) ? rd_seg.start_y : rd_seg.end_y;
    assign y_hi         = (rd_seg.start_y < rd_seg.end_y) ? rd_seg.end_y : rd_seg.start_y;
    assign entry_hit    = ({1'b0, scan_idx} < front_count) && (y_lo <= tgt_q) && (tgt_q <= y_hi);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (search_start) state_d = SCAN;
            SCAN:    if (last_entry) state_d = LOAD;
            LOAD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Only the lowest-index hit is kept; endpoints hold when nothing covers the line.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            scan_idx  <= '0;
            scan_bank <= 1'b0;
            tgt_q     <= '0;
            found_q   <= 1'b0;
            match_q   <= '0;
            start_x   <= '0;
            end_x     <= '0;
            start_y   <= '0;
            end_y     <= '0;
            seg_valid <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (search_start) begin
                        scan_idx  <= '0;
                        scan_bank <= bank_sel;
                        tgt_q     <= line_tgt;
                        found_q   <= 1'b0;
                    end
                end
                SCAN: begin
                    if (entry_hit && !found_q) begin
                        found_q <= 1'b1;
                        match_q <= rd_seg;
                    end
                    scan_idx <= scan_idx + 1'b1;
                end
                LOAD: begin
                    seg_valid <= found_q;
                    if (found_q) begin
                        start_x <= match_q.start_x;
                        end_x   <= match_q.end_x;
                        start_y <= match_q.start_y;
                        end_y   <= match_q.end_y;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_segment_sequencer.sv
// Bench for segment_sequencer: compressed scanlines (hcount jumps straight into
// blanking) driven against a table-level reference model.
module tb_segment_sequencer;

    localparam int MAX_SEGS = 8;
    localparam int H_ACTIVE = 1024;
    localparam int H_TOTAL  = 1344;
    localparam int V_ACTIVE = 768;
    localparam int V_TOTAL  = 806;
    localparam int LOAD_H   = H_ACTIVE + MAX_SEGS + 1;

    typedef struct {
        int sx;
        int ex;
        int sy;
        int ey;
    } mseg_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic        wr_en;
    logic [2:0]  wr_idx;
    logic [10:0] wr_start_x, wr_end_x;
    logic [9:0]  wr_start_y, wr_end_y;
    logic        wr_commit;
    logic [3:0]  wr_count;
    logic        wr_ready;
    logic [10:0] start_x, end_x;
    logic [9:0]  start_y, end_y;
    logic        seg_valid;
    logic        frame_swapped;
    logic [42:0] outv;

    int tot = 0;
    int bad = 0;
    int swap_pulses = 0;

    mseg_t       m_front [MAX_SEGS];
    mseg_t       m_back  [MAX_SEGS];
    int          m_fcount;
    int          m_pcount;
    bit          m_pending;
    logic [42:0] exp_out;

    logic        obs_ready, obs_swapped;
    logic        line_ready0, line_swapped0;
    logic [42:0] out_pre, out_post;

    always #5 clk = ~clk;

    assign outv = {seg_valid, start_x, end_x, start_y, end_y};

    segment_sequencer #(
        .MAX_SEGS      (MAX_SEGS),
        .H_ACTIVE      (H_ACTIVE),
        .H_TOTAL       (H_TOTAL),
        .V_ACTIVE      (V_ACTIVE),
        .V_TOTAL       (V_TOTAL)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .hcount        (hcount),
        .vcount        (vcount),
        .wr_en         (wr_en),
        .wr_idx        (wr_idx),
        .wr_start_x    (wr_start_x),
        .wr_end_x      (wr_end_x),
        .wr_start_y    (wr_start_y),
        .wr_end_y      (wr_end_y),
        .wr_commit     (wr_commit),
        .wr_count      (wr_count),
        .wr_ready      (wr_ready),
        .start_x       (start_x),
        .end_x         (end_x),
        .start_y       (start_y),
        .end_y         (end_y),
        .seg_valid     (seg_valid),
        .frame_swapped (frame_swapped)
    );

    function automatic logic [42:0] mk(input bit v, input int sx, input int ex,
                                       input int sy, input int ey);
        return {v, 11'(sx), 11'(ex), 10'(sy), 10'(ey)};
    endfunction

    function automatic void model_reset();
        m_fcount  = 0;
        m_pcount  = 0;
        m_pending = 0;
        exp_out   = '0;
    endfunction

    // First segment of the front table whose y span contains the next line.
    function automatic void model_search(input int v);
        int tgt;
        int lo, hi;
        tgt = (v == V_TOTAL - 1) ? 0 : v + 1;
        for (int i = 0; i < m_fcount; i++) begin
            lo = (m_front[i].sy < m_front[i].ey) ? m_front[i].sy : m_front[i].ey;
            hi = (m_front[i].sy < m_front[i].ey) ? m_front[i].ey : m_front[i].sy;
            if (lo <= tgt && tgt <= hi) begin
                exp_out = mk(1'b1, m_front[i].sx, m_front[i].ex, m_front[i].sy, m_front[i].ey);
                return;
            end
        end
        exp_out[42] = 1'b0;
    endfunction

    // One clock with the given timing position; host inputs are taken as already driven.
    task automatic cycle(input int h, input int v);
        bit     boundary;
        bit     swap_now;
        mseg_t  tmp [MAX_SEGS];
        hcount = 11'(h);
        vcount = 10'(v);
        #2;
        obs_ready   = wr_ready;
        obs_swapped = frame_swapped;
        if (obs_swapped === 1'b1) swap_pulses++;
        boundary = (h == 0 && v == V_ACTIVE);
        swap_now = boundary && m_pending;
        if (wr_en && !boundary && int'(wr_idx) < MAX_SEGS)
            m_back[wr_idx] = '{int'(wr_start_x), int'(wr_end_x), int'(wr_start_y), int'(wr_end_y)};
        if (swap_now) begin
            tmp      = m_front;
            m_front  = m_back;
            m_back   = tmp;
            m_fcount = m_pcount;
        end
        if (wr_commit) begin
            m_pending = 1;
            m_pcount  = (int'(wr_count) > MAX_SEGS) ? MAX_SEGS : int'(wr_count);
        end else if (swap_now) begin
            m_pending = 0;
        end
        @(posedge clk);
        #1;
        wr_en     = 1'b0;
        wr_commit = 1'b0;
    endtask

    task automatic run_line(input int v);
        cycle(0, v);
        line_ready0   = obs_ready;
        line_swapped0 = obs_swapped;
        for (int h = H_ACTIVE; h <= H_ACTIVE + MAX_SEGS + 3; h++) begin
            cycle(h, v);
            if (h == LOAD_H - 1) out_pre = outv;
            if (h == LOAD_H) out_post = outv;
        end
        model_search(v);
    endtask

    task automatic host_write(input int idx, input int sx, input int ex, input int sy, input int ey);
        wr_en      = 1'b1;
        wr_idx     = 3'(idx);
        wr_start_x = 11'(sx);
        wr_end_x   = 11'(ex);
        wr_start_y = 10'(sy);
        wr_end_y   = 10'(ey);
        cycle(5, 700);
    endtask

    task automatic host_commit(input int cnt);
        wr_commit = 1'b1;
        wr_count  = 4'(cnt);
        cycle(5, 700);
    endtask

    task automatic test_reset();
        int bad_lines;
        int v;
        tot++;
        if ({outv, frame_swapped, wr_ready} !== {43'd0, 1'b0, 1'b1}) begin
            bad++;
            $display("[TB] FAIL reset_state: got %h/%b/%b want 0/0/1", outv, frame_swapped, wr_ready);
        end
        reset = 1'b0;
        host_write(0, 7, 8, 0, 805);
        host_commit(1);
        run_line(768);
        run_line(10);
        tot++;
        if (out_post !== mk(1'b1, 7, 8, 0, 805)) begin
            bad++;
            $display("[TB] FAIL reset_prep: got %h want %h", out_post, mk(1'b1, 7, 8, 0, 805));
        end
        for (int h = H_ACTIVE; h < 1028; h++) cycle(h, 11);
        hcount = 11'd1028;
        #2;
        reset = 1'b1;
        #1;
        tot++;
        if ({outv, frame_swapped, wr_ready} !== {43'd0, 1'b0, 1'b1}) begin
            bad++;
            $display("[TB] FAIL reset_async: got %h/%b/%b want 0/0/1", outv, frame_swapped, wr_ready);
        end
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int h = 1029; h <= 1036; h++) cycle(h, 11);
        swap_pulses = 0;
        bad_lines   = 0;
        for (int n = 0; n < V_TOTAL; n++) begin
            v = (12 + n) % V_TOTAL;
            run_line(v);
            if (out_post !== 43'd0) bad_lines++;
        end
        tot++;
        if (bad_lines !== 0) begin
            bad++;
            $display("[TB] FAIL reset_frame_idle: got %0d active lines want 0", bad_lines);
        end
        tot++;
        if (swap_pulses !== 0) begin
            bad++;
            $display("[TB] FAIL reset_no_swap: got %0d pulses want 0", swap_pulses);
        end
    endtask

    task automatic test_basic();
        logic [42:0] prev;
        host_write(0, 100, 300, 200, 400);
        host_commit(1);
        run_line(768);
        tot++;
        if ({line_swapped0, line_ready0} !== 2'b10) begin
            bad++;
            $display("[TB] FAIL basic_swap_pulse: got swapped=%b ready=%b want 1/0", line_swapped0, line_ready0);
        end
        run_line(198);
        prev = exp_out;
        run_line(199);
        tot++;
        if (out_pre !== prev) begin
            bad++;
            $display("[TB] FAIL basic_latency: got %h at hcount %0d want %h", out_pre, LOAD_H - 1, prev);
        end
        tot++;
        if (out_post !== mk(1'b1, 100, 300, 200, 400)) begin
            bad++;
            $display("[TB] FAIL basic_select: got %h want %h", out_post, mk(1'b1, 100, 300, 200, 400));
        end
        run_line(400);
        tot++;
        if (out_post !== mk(1'b0, 100, 300, 200, 400)) begin
            bad++;
            $display("[TB] FAIL basic_hold: got %h want %h", out_post, mk(1'b0, 100, 300, 200, 400));
        end
    endtask

    task automatic test_priority();
        int          lines [3] = '{14, 20, 30};
        logic [42:0] want  [3];
        want[0] = mk(1'b1, 1, 2, 10, 20);
        want[1] = mk(1'b1, 3, 4, 15, 30);
        want[2] = mk(1'b0, 3, 4, 15, 30);
        host_write(0, 1, 2, 10, 20);
        host_write(1, 3, 4, 15, 30);
        host_commit(2);
        run_line(768);
        for (int k = 0; k < 3; k++) begin
            run_line(lines[k]);
            tot++;
            if (out_post !== want[k]) begin
                bad++;
                $display("[TB] FAIL priority_line%0d: got %h want %h", lines[k] + 1, out_post, want[k]);
            end
        end
    endtask

    task automatic test_reversed();
        bit want;
        host_write(0, 5, 6, 50, 40);
        host_commit(1);
        run_line(768);
        for (int v = 38; v <= 50; v++) begin
            want = (v + 1 >= 40) && (v + 1 <= 50);
            run_line(v);
            tot++;
            if (out_post[42] !== want || (want && out_post !== mk(1'b1, 5, 6, 50, 40))) begin
                bad++;
                $display("[TB] FAIL reversed_line%0d: got %h want valid=%b", v + 1, out_post, want);
            end
        end
    endtask

    task automatic test_swap_cycle();
        host_write(0, 60, 70, 100, 110);
        wr_en      = 1'b1;
        wr_idx     = 3'd1;
        wr_start_x = 11'd80;
        wr_end_x   = 11'd90;
        wr_start_y = 10'd500;
        wr_end_y   = 10'd510;
        wr_commit  = 1'b1;
        wr_count   = 4'd2;
        run_line(768);
        tot++;
        if ({line_ready0, line_swapped0} !== 2'b00) begin
            bad++;
            $display("[TB] FAIL swapcyc_ready: got ready=%b swapped=%b want 0/0", line_ready0, line_swapped0);
        end
        run_line(44);
        tot++;
        if (out_post !== mk(1'b1, 5, 6, 50, 40)) begin
            bad++;
            $display("[TB] FAIL swapcyc_no_swap: got %h want %h", out_post, mk(1'b1, 5, 6, 50, 40));
        end
        run_line(767);
        run_line(768);
        tot++;
        if (line_swapped0 !== 1'b1) begin
            bad++;
            $display("[TB] FAIL swapcyc_next_frame: got %b want 1", line_swapped0);
        end
        run_line(104);
        tot++;
        if (out_post !== mk(1'b1, 60, 70, 100, 110)) begin
            bad++;
            $display("[TB] FAIL swapcyc_new_front: got %h want %h", out_post, mk(1'b1, 60, 70, 100, 110));
        end
        run_line(504);
        tot++;
        if (out_post !== mk(1'b0, 60, 70, 100, 110)) begin
            bad++;
            $display("[TB] FAIL swapcyc_write_dropped: got %h want %h", out_post, mk(1'b0, 60, 70, 100, 110));
        end
        run_line(19);
        tot++;
        if (out_post !== mk(1'b1, 3, 4, 15, 30)) begin
            bad++;
            $display("[TB] FAIL swapcyc_stale: got %h want %h", out_post, mk(1'b1, 3, 4, 15, 30));
        end
    endtask

    task automatic test_wrap_clamp();
        host_write(0, 11, 22, 0, 5);
        for (int i = 1; i < 7; i++)
            host_write(i, $urandom_range(0, 2047), $urandom_range(0, 2047),
                       $urandom_range(200, 300), $urandom_range(200, 300));
        host_write(7, 33, 44, 690, 710);
        host_commit(15);
        run_line(768);
        run_line(805);
        tot++;
        if (out_post !== mk(1'b1, 11, 22, 0, 5)) begin
            bad++;
            $display("[TB] FAIL wrap_line0: got %h want %h", out_post, mk(1'b1, 11, 22, 0, 5));
        end
        run_line(804);
        tot++;
        if (out_post !== mk(1'b0, 11, 22, 0, 5)) begin
            bad++;
            $display("[TB] FAIL wrap_line805: got %h want %h", out_post, mk(1'b0, 11, 22, 0, 5));
        end
        run_line(699);
        tot++;
        if (out_post !== mk(1'b1, 33, 44, 690, 710)) begin
            bad++;
            $display("[TB] FAIL clamp_last_entry: got %h want %h", out_post, mk(1'b1, 33, 44, 690, 710));
        end
    endtask

    task automatic test_random();
        int sy, ey, k, v;
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < MAX_SEGS; i++) begin
                sy = $urandom_range(0, 805);
                ey = sy + $urandom_range(0, 80);
                if (ey > 1023) ey = 1023;
                if ($urandom_range(0, 1) == 1)
                    host_write(i, $urandom_range(0, 2047), $urandom_range(0, 2047), ey, sy);
                else
                    host_write(i, $urandom_range(0, 2047), $urandom_range(0, 2047), sy, ey);
            end
            host_commit($urandom_range(0, 15));
            host_commit($urandom_range(1, 15));
            run_line(768);
            tot++;
            if (line_swapped0 !== 1'b1) begin
                bad++;
                $display("[TB] FAIL random_swap_r%0d: got %b want 1", r, line_swapped0);
            end
            for (int n = 0; n < 12; n++) begin
                if (n % 2 == 0) begin
                    v = $urandom_range(0, V_TOTAL - 1);
                end else begin
                    k = $urandom_range(0, m_fcount - 1);
                    v = ((m_front[k].sy < m_front[k].ey) ? m_front[k].sy : m_front[k].ey)
                        + $urandom_range(0, 90) - 3;
                    if (v < 0) v = 0;
                    if (v > V_TOTAL - 1) v = V_TOTAL - 1;
                end
                run_line(v);
                tot++;
                if (out_post !== exp_out) begin
                    bad++;
                    $display("[TB] FAIL random_r%0d_line%0d: got %h want %h", r, v, out_post, exp_out);
                end
            end
        end
    endtask

    initial begin
        reset      = 1'b1;
        hcount     = 11'd5;
        vcount     = 10'd0;
        wr_en      = 1'b0;
        wr_idx     = '0;
        wr_start_x = '0;
        wr_end_x   = '0;
        wr_start_y = '0;
        wr_end_y   = '0;
        wr_commit  = 1'b0;
        wr_count   = '0;
        for (int i = 0; i < MAX_SEGS; i++) begin
            m_front[i] = '{0, 0, 0, 0};
            m_back[i]  = '{0, 0, 0, 0};
        end
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_priority();
        test_reversed();
        test_swap_cycle();
        test_wrap_clamp();
        test_random();
        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end

endmodule
